// File: rtl/a_buf_loader_pkg.sv
// Shared widths and FSM encoding for the A-operand buffer write-side loader.
package a_buf_loader_pkg;

  localparam int TMMA_CNT_WIDTH    = 6;
  localparam int SARRAY_LOAD_WIDTH = 32;
  localparam int A_BUF_NUM         = 2;

  typedef enum logic [1:0] {
    LDR_IDLE     = 2'd0,
    LDR_WAIT_BUF = 2'd1,
    LDR_FILL     = 2'd2,
    LDR_FLUSH    = 2'd3
  } ldr_state_e;

  function automatic logic [A_BUF_NUM-1:0] buf_onehot(input logic id);
    return A_BUF_NUM'(1) << id;
  endfunction

endpackage

// File: rtl/a_buf_owner_trk.sv
// Per-buffer ownership flags: set when a buffer is published, cleared on feeder release.
module a_buf_owner_trk
  import a_buf_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_set,
  input  logic                 i_set_id,
  input  logic                 i_rel,
  input  logic                 i_rel_id,
  output logic [A_BUF_NUM-1:0] o_buf_full
);

  logic [A_BUF_NUM-1:0] r_full;
  logic [A_BUF_NUM-1:0] w_set_mask;
  logic [A_BUF_NUM-1:0] w_rel_mask;

  assign w_set_mask = i_set ? buf_onehot(i_set_id) : '0;
  assign w_rel_mask = i_rel ? buf_onehot(i_rel_id) : '0;

  // Releasing a non-full buffer is a no-op; set wins if both ever hit one id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
    end else begin
      r_full <= (r_full & ~w_rel_mask) | w_set_mask;
    end
  end

  assign o_buf_full = r_full;

endmodule

// File: rtl/a_buf_loader.sv
// Write-side controller for the A-operand ping-pong buffer: takes a tile-load
// command and row beats, writes a_buf, and publishes each filled buffer.
//
// state        | meaning
// LDR_IDLE     | ready for a tile-load command
// LDR_WAIT_BUF | target buffer still owned by the feeder, waiting for release
// LDR_FILL     | accepting row beats, one a_buf write per accepted beat
// LDR_FLUSH    | last write on the bus; mark buffer full, flip write id
module a_buf_loader
  import a_buf_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_start_i,
  input  logic [TMMA_CNT_WIDTH-1:0]    ld_rows_m1_i,
  output logic                         ld_start_ready_o,
  input  logic                         ld_data_valid_i,
  input  logic [SARRAY_LOAD_WIDTH-1:0] ld_data_i,
  output logic                         ld_data_ready_o,
  output logic                         wr_a_buf_valid_o,
  output logic                         wr_a_buf_id_o,
  output logic [TMMA_CNT_WIDTH-1:0]    wr_a_buf_addr_o,
  output logic [SARRAY_LOAD_WIDTH-1:0] wr_a_buf_data_o,
  output logic                         fill_done_o,
  output logic                         fill_done_id_o,
  output logic [TMMA_CNT_WIDTH-1:0]    fill_done_rows_m1_o,
  input  logic                         buf_release_i,
  input  logic                         buf_release_id_i,
  output logic [A_BUF_NUM-1:0]         buf_full_o
);

  ldr_state_e                   r_state;
  logic                         r_wr_id;
  logic [TMMA_CNT_WIDTH-1:0]    r_row_cnt;
  logic [TMMA_CNT_WIDTH-1:0]    r_rows_m1;
  logic                         r_wr_valid;
  logic                         r_wr_buf_id;
  logic [TMMA_CNT_WIDTH-1:0]    r_wr_addr;
  logic [SARRAY_LOAD_WIDTH-1:0] r_wr_data;
  logic                         r_fill_done;
  logic                         r_fill_id;
  logic [TMMA_CNT_WIDTH-1:0]    r_fill_rows_m1;

  logic [A_BUF_NUM-1:0] w_buf_full;
  logic                 w_beat;
  logic                 w_rel_hit;
  logic                 w_target_busy;
  logic                 w_flush;

  assign w_beat    = ld_data_valid_i && (r_state == LDR_FILL);
  assign w_flush   = (r_state == LDR_FLUSH);
  assign w_rel_hit = buf_release_i && (buf_release_id_i == r_wr_id);
  // A release of the target this cycle lets FILL start on the next cycle.
  assign w_target_busy = w_buf_full[r_wr_id] && !w_rel_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= LDR_IDLE;
      r_wr_id        <= 1'b0;
      r_row_cnt      <= '0;
      r_rows_m1      <= '0;
      r_wr_valid     <= 1'b0;
      r_wr_buf_id    <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_fill_done    <= 1'b0;
      r_fill_id      <= 1'b0;
      r_fill_rows_m1 <= '0;
    end else begin
      r_wr_valid  <= 1'b0;
      r_fill_done <= 1'b0;
      case (r_state)
        LDR_IDLE: begin
          if (ld_start_i) begin
            r_rows_m1 <= ld_rows_m1_i;
            r_state   <= LDR_WAIT_BUF;
          end
        end
        LDR_WAIT_BUF: begin
          if (!w_target_busy) begin
            r_row_cnt <= '0;
            r_state   <= LDR_FILL;
          end
        end
        LDR_FILL: begin
          if (w_beat) begin
            r_wr_valid  <= 1'b1;
            r_wr_buf_id <= r_wr_id;
            r_wr_addr   <= r_row_cnt;
            r_wr_data   <= ld_data_i;
            // Counter holds on the last row so rows_m1=63 never wraps.
            if (r_row_cnt == r_rows_m1) begin
              r_state <= LDR_FLUSH;
            end else begin
              r_row_cnt <= r_row_cnt + TMMA_CNT_WIDTH'(1);
            end
          end
        end
        LDR_FLUSH: begin
          r_fill_done    <= 1'b1;
          r_fill_id      <= r_wr_id;
          r_fill_rows_m1 <= r_rows_m1;
          r_wr_id        <= ~r_wr_id;
          r_state        <= LDR_IDLE;
        end
        default: r_state <= LDR_IDLE;
      endcase
    end
  end

  a_buf_owner_trk u_owner_trk (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set      (w_flush),
    .i_set_id   (r_wr_id),
    .i_rel      (buf_release_i),
    .i_rel_id   (buf_release_id_i),
    .o_buf_full (w_buf_full)
  );

  assign ld_start_ready_o    = (r_state == LDR_IDLE);
  assign ld_data_ready_o     = (r_state == LDR_FILL);
  assign wr_a_buf_valid_o    = r_wr_valid;
  assign wr_a_buf_id_o       = r_wr_buf_id;
  assign wr_a_buf_addr_o     = r_wr_addr;
  assign wr_a_buf_data_o     = r_wr_data;
  assign fill_done_o         = r_fill_done;
  assign fill_done_id_o      = r_fill_id;
  assign fill_done_rows_m1_o = r_fill_rows_m1;
  assign buf_full_o          = w_buf_full;

endmodule
